// File: rtl/axi_led_pkg.sv
// axi_led_pkg: shared types, register offsets and field positions
// for the AXI4-Lite LED/PWM controller.
package axi_led_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        PWM   = 2'd3
    } led_mode_e;

    // Register word indices (byte offset / 4)
    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_PRESCALE = 2;
    localparam int REG_CH0      = 4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_SCLR = 1;

    localparam int MODE_LSB = 0;
    localparam int DUTY_LSB = 8;
    localparam int HALF_LSB = 16;

    localparam logic [31:0] CH_MASK = 32'h00FF_FF03;

endpackage

// File: rtl/axi_led_pwm_ctrl_channel.sv
// led_channel: one LED output; owns its blink counter and phase,
// selects off/on/blink/pwm and registers the drive.
module led_channel
    import axi_led_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_en,
    input  logic      i_clr,
    input  logic      i_tick,
    input  led_mode_e i_mode,
    input  logic [7:0] i_duty,
    input  logic [7:0] i_half,
    input  logic [7:0] i_pwm_cnt,
    output logic      o_led
);

    logic [7:0] r_cnt;
    logic       r_phase;
    logic       r_led;
    logic       w_led;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_tick) begin
            if (r_cnt == i_half) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_led = 1'b0;
        unique case (i_mode)
            OFF:   w_led = 1'b0;
            ON:    w_led = 1'b1;
            BLINK: w_led = r_phase;
            PWM:   w_led = (i_pwm_cnt < i_duty);
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_led <= 1'b0;
        else       r_led <= i_en && w_led;
    end

    assign o_led = r_led;

endmodule

// File: rtl/axi_led_pwm_ctrl.sv
// axi_led_pwm_ctrl: AXI4-Lite slave with per-channel off/on/blink/PWM LEDs.
// Define LED_WSTRB_EN to honour WSTRB byte lanes on register writes.
module axi_led_pwm_ctrl
    import axi_led_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_LEDS           = 4,
    parameter int PRESCALE_RST       = 100
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]           LED_O
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;

    logic          r_awready, r_wready, r_bvalid;
    logic          r_aw_held, r_w_held;
    logic [IW-1:0] r_aw_idx;
    logic [31:0]   r_wdata;
    logic          r_arready, r_rvalid;
    logic [31:0]   r_rdata;

    logic          r_en, r_sclr;
    logic [15:0]   r_prescale;
    logic [31:0]   r_ch [NUM_LEDS];
    logic [15:0]   r_pre_cnt;
    logic [7:0]    r_pwm_cnt;

    logic                w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
    logic [IW-1:0]       w_ar_idx;
    logic [31:0]         w_rdata, w_ctrl_wr, w_pre_wr;
    logic                w_wr_ctrl, w_wr_pre;
    logic [NUM_LEDS-1:0] w_ch_wr;
    logic [NUM_LEDS-1:0] w_led;
    logic                w_run, w_tick;
    logic                w_unused;

`ifdef LED_WSTRB_EN
    logic [3:0] r_wstrb;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)      r_wstrb <= '0;
        else if (w_w_hs) r_wstrb <= S_AXI_WSTRB;
    end

    function automatic logic [31:0] f_wr(input logic [31:0] old);
        logic [31:0] v;
        for (int b = 0; b < 4; b++)
            v[8*b +: 8] = r_wstrb[b] ? r_wdata[8*b +: 8] : old[8*b +: 8];
        return v;
    endfunction

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        w_ctrl_wr[31:2], w_pre_wr[31:16]};
`else
    function automatic logic [31:0] f_wr(input logic [31:0] old);
        return r_wdata | (old & 32'h0);
    endfunction

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        w_ctrl_wr[31:2], w_pre_wr[31:16]};
`endif

    assign w_aw_hs   = r_awready && S_AXI_AWVALID;
    assign w_w_hs    = r_wready && S_AXI_WVALID;
    assign w_ar_hs   = r_arready && S_AXI_ARVALID;
    assign w_wr_fire = r_aw_held && r_w_held && !r_bvalid;

    // Write address/data: one-cycle READY pulses, beats held until the update
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= S_AXI_AWVALID && !r_awready && !r_aw_held && !r_bvalid;
            r_wready  <= S_AXI_WVALID && !r_wready && !r_w_held && !r_bvalid;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[AW-1:2];
            end else if (w_wr_fire) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= 32'(S_AXI_WDATA);
            end else if (w_wr_fire) begin
                r_w_held <= 1'b0;
            end
            if (w_wr_fire)
                r_bvalid <= 1'b1;
            else if (r_bvalid && S_AXI_BREADY)
                r_bvalid <= 1'b0;
        end
    end

    assign w_ctrl_wr = f_wr({31'b0, r_en});
    assign w_pre_wr  = f_wr({16'b0, r_prescale});
    assign w_wr_ctrl = (int'(r_aw_idx) == REG_CTRL);
    assign w_wr_pre  = (int'(r_aw_idx) == REG_PRESCALE);

    always_comb begin
        w_ch_wr = '0;
        for (int n = 0; n < NUM_LEDS; n++)
            w_ch_wr[n] = w_wr_fire && (int'(r_aw_idx) == REG_CH0 + n);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_en       <= 1'b0;
            r_sclr     <= 1'b0;
            r_prescale <= 16'(PRESCALE_RST);
            for (int n = 0; n < NUM_LEDS; n++) r_ch[n] <= '0;
        end else begin
            r_sclr <= 1'b0;
            if (w_wr_fire && w_wr_ctrl) begin
                r_en   <= w_ctrl_wr[CTRL_EN];
                r_sclr <= w_ctrl_wr[CTRL_SCLR];
            end
            if (w_wr_fire && w_wr_pre)
                r_prescale <= w_pre_wr[15:0];
            for (int n = 0; n < NUM_LEDS; n++)
                if (w_ch_wr[n]) r_ch[n] <= f_wr(r_ch[n]) & CH_MASK;
        end
    end

    assign w_ar_idx = S_AXI_ARADDR[AW-1:2];

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            (int'(w_ar_idx) == REG_CTRL):     w_rdata[CTRL_EN] = r_en;
            (int'(w_ar_idx) == REG_STATUS):   w_rdata[NUM_LEDS-1:0] = w_led;
            (int'(w_ar_idx) == REG_PRESCALE): w_rdata[15:0] = r_prescale;
            default: begin
                for (int n = 0; n < NUM_LEDS; n++)
                    if (int'(w_ar_idx) == REG_CH0 + n) w_rdata = r_ch[n];
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= S_AXI_ARVALID && !r_arready && !r_rvalid;
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Prescaler and shared PWM counter; held at zero while disabled/clearing
    assign w_run  = r_en && !r_sclr;
    assign w_tick = w_run && (r_pre_cnt >= r_prescale);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (!w_run) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_channel u_ch (
            .i_clk     (ACLK),
            .i_rst     (ARESET),
            .i_en      (r_en),
            .i_clr     (!w_run || w_ch_wr[g]),
            .i_tick    (w_tick),
            .i_mode    (led_mode_e'(r_ch[g][MODE_LSB +: 2])),
            .i_duty    (r_ch[g][DUTY_LSB +: 8]),
            .i_half    (r_ch[g][HALF_LSB +: 8]),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[g])
        );
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_rdata);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_rvalid;
    assign LED_O         = w_led;

endmodule

// File: tb/tb_axi_led_pwm_ctrl.sv
// tb_axi_led_pwm_ctrl: directed checks of the AXI LED/PWM controller.
// Build with LED_WSTRB_EN to exercise byte-lane writes.
module tb_axi_led_pwm_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [5:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = 4'hF;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b1;
    logic [5:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b1;
    logic [3:0]  LED_O;

    int total = 0;
    int bad = 0;

    axi_led_pwm_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .LED_O(LED_O)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_ok = 0;
        bit w_ok = 0;
        bit b_ok = 0;
        resp = 2'bxx;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        for (int n = 0; n < 50 && !(aw_ok && w_ok); n++) begin
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_ok = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_ok = 1;
            tick1();
            if (aw_ok) S_AXI_AWVALID = 1'b0;
            if (w_ok) S_AXI_WVALID = 1'b0;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int n = 0; n < 50 && !b_ok; n++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin b_ok = 1; resp = S_AXI_BRESP; end
            tick1();
        end
        if (!(aw_ok && w_ok && b_ok))
            chk("wr_timeout", {29'b0, aw_ok, w_ok, b_ok}, 32'h7);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        bit ar_ok = 0;
        bit r_ok = 0;
        d = 'x; resp = 2'bxx;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        for (int n = 0; n < 50 && !ar_ok; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) ar_ok = 1;
            tick1();
        end
        S_AXI_ARVALID = 1'b0;
        for (int n = 0; n < 50 && !r_ok; n++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin
                r_ok = 1; d = S_AXI_RDATA; resp = S_AXI_RRESP;
            end
            tick1();
        end
        if (!(ar_ok && r_ok))
            chk("rd_timeout", {30'b0, ar_ok, r_ok}, 32'h3);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs, ws;
        int cnt;
        bit seen;
        bit aw_ok, w_ok;

        // Reset
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_led", {28'b0, LED_O}, 32'h0);
        chk("rst_hs", {27'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                       S_AXI_ARREADY, S_AXI_RVALID}, 32'h0);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        tick1();
        axi_read(6'h08, rd, rs);
        chk("rst_prescale", rd, 32'd100);
        axi_read(6'h00, rd, rs);
        chk("rst_ctrl", rd, 32'h0);

        // 1: basic write/readback
        axi_write(6'h00, 32'h1, 4'hF, ws);
        chk("t1_bresp", {30'b0, ws}, 32'h0);
        axi_write(6'h10, 32'h0000_0301, 4'hF, ws);
        axi_read(6'h00, rd, rs);
        chk("t1_ctrl", rd, 32'h1);
        axi_read(6'h10, rd, rs);
        chk("t1_ch0", rd, 32'h301);
        chk("t1_rresp", {30'b0, rs}, 32'h0);
        axi_read(6'h04, rd, rs);
        chk("t1_status", rd, 32'h1);
        axi_write(6'h00, 32'h3, 4'hF, ws);
        axi_read(6'h00, rd, rs);
        chk("t1_sclr_reads0", rd, 32'h1);

        // 2: PWM duty 0x40 at full-rate tick
        axi_write(6'h08, 32'h0, 4'hF, ws);
        axi_write(6'h14, 32'h0000_4003, 4'hF, ws);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge ACLK);
            cnt += int'(LED_O[1]);
        end
        tick1();
        chk("t2_pwm_high", cnt, 32'd64);
        chk("t2_led0_on", {31'b0, LED_O[0]}, 32'h1);

        // 3: blink, prescale 4, half-period 2 -> 15-cycle half-periods
        axi_write(6'h08, 32'h4, 4'hF, ws);
        axi_write(6'h18, 32'h0002_0002, 4'hF, ws);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge ACLK);
            if (LED_O[2]) seen = 1;
        end
        chk("t3_rise", {31'b0, seen}, 32'h1);
        cnt = 0;
        while (LED_O[2] && cnt < 40) begin
            cnt++;
            @(negedge ACLK);
        end
        chk("t3_high_len", cnt, 32'd15);
        cnt = 0;
        while (!LED_O[2] && cnt < 40) begin
            cnt++;
            @(negedge ACLK);
        end
        chk("t3_low_len", cnt, 32'd15);
        axi_write(6'h18, 32'h0002_0002, 4'hF, ws);
        chk("t3_restart_low", {31'b0, LED_O[2]}, 32'h0);
        repeat (5) tick1();
        chk("t3_still_low", {31'b0, LED_O[2]}, 32'h0);

        // 4: AW three cycles before W, BREADY held off
        aw_ok = 0; w_ok = 0;
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_ok = 1;
            tick1();
            if (aw_ok) S_AXI_AWVALID = 1'b0;
        end
        chk("t4_aw_first", {31'b0, aw_ok}, 32'h1);
        S_AXI_WDATA = 32'h1234; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !w_ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_WREADY) w_ok = 1;
            tick1();
        end
        S_AXI_WVALID = 1'b0;
        chk("t4_w_accept", {31'b0, w_ok}, 32'h1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) seen = 1;
            tick1();
        end
        chk("t4_bvalid", {31'b0, seen}, 32'h1);
        S_AXI_AWADDR = 6'h1C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("t4_hold", {29'b0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY},
                32'h4);
            tick1();
        end
        axi_write(6'h1C, 32'h1, 4'hF, ws);
        axi_read(6'h08, rd, rs);
        chk("t4_prescale", rd, 32'h1234);
        axi_read(6'h1C, rd, rs);
        chk("t4_ch3", rd, 32'h1);

        // 5: unmapped and out-of-range channel
        axi_read(6'h3C, rd, rs);
        chk("t5_rd_3c", {rd[31:2], rs}, 32'h0);
        chk("t5_rd_3c_lo", {30'b0, rd[1:0]}, 32'h0);
        axi_read(6'h24, rd, rs);
        chk("t5_rd_ch5", rd, 32'h0);
        chk("t5_rresp", {30'b0, rs}, 32'h0);
        axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, ws);
        chk("t5_bresp", {30'b0, ws}, 32'h0);
        axi_write(6'h24, 32'hFFFF_FFFF, 4'hF, ws);
        axi_read(6'h24, rd, rs);
        chk("t5_ch5_after", rd, 32'h0);
        axi_read(6'h00, rd, rs);
        chk("t5_ctrl_kept", rd, 32'h1);
        axi_read(6'h14, rd, rs);
        chk("t5_ch1_kept", rd, 32'h4003);
        axi_read(6'h08, rd, rs);
        chk("t5_pre_kept", rd, 32'h1234);

        // 6: async reset during fast blink
        axi_write(6'h08, 32'h0, 4'hF, ws);
        axi_write(6'h10, 32'h0000_0002, 4'hF, ws);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            if (LED_O[0]) seen = 1;
        end
        chk("t6_blinking", {31'b0, seen}, 32'h1);
        ARESET = 1'b1;
        #1;
        chk("t6_led_zero", {28'b0, LED_O}, 32'h0);
        chk("t6_bus_idle", {27'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                            S_AXI_ARREADY, S_AXI_RVALID}, 32'h0);
        tick1();
        ARESET = 1'b0;
        tick1();
        axi_read(6'h00, rd, rs);
        chk("t6_ctrl", rd, 32'h0);
        axi_read(6'h08, rd, rs);
        chk("t6_prescale", rd, 32'd100);

        // Byte-lane write on CH0 (reset value 0)
        axi_write(6'h10, 32'hFFFF_FFFF, 4'h2, ws);
        axi_read(6'h10, rd, rs);
`ifdef LED_WSTRB_EN
        chk("wstrb_ch0", rd, 32'h0000_FF00);
`else
        chk("wstrb_ch0", rd, 32'h00FF_FF03);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
